// File: rtl/fp_norm_pipe.sv
// Two-stage floating-point mantissa normalizer: stage 1 counts leading zeros, stage 2 shifts and adjusts the exponent.
// Optional macro FP_NORM_DENORM_EN: caps the shift so the adjusted exponent never drops below 1.
module fp_norm_pipe #(
    parameter int XLEN = 64,
    parameter int XLOG = 6,
    parameter int ELEN = 13
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_mant,
    input  logic [ELEN-1:0] in_exp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_mant,
    output logic [ELEN-1:0] out_exp,
    output logic [XLOG-1:0] out_shift,
    output logic            out_zero
);

    logic            s1_adv, s2_adv;
    logic [XLOG-1:0] lz;
    logic            mant_zero;
    logic [XLOG-1:0] shift;

    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_mant_q, s1_mant_d;
    logic [ELEN-1:0] s1_exp_q, s1_exp_d;
    logic [XLOG-1:0] s1_lz_q, s1_lz_d;
    logic            s1_zero_q, s1_zero_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_mant_q, out_mant_d;
    logic [ELEN-1:0] out_exp_q, out_exp_d;
    logic [XLOG-1:0] out_shift_q, out_shift_d;
    logic            out_zero_q, out_zero_d;

    // Ready flows backwards combinationally; valid never feeds ready.
    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        lz        = '0;
        mant_zero = (in_mant == '0);
        for (int i = 0; i < XLEN; i++) begin
            if (in_mant[i]) lz = XLOG'(XLEN - 1 - i);
        end
    end

`ifdef FP_NORM_DENORM_EN
    localparam int W = ((ELEN > XLOG) ? ELEN : XLOG) + 2;
    logic signed [W-1:0] exp_w, lz_w, cap_w;

    always_comb begin
        exp_w = {{(W-ELEN){s1_exp_q[ELEN-1]}}, s1_exp_q};
        lz_w  = {{(W-XLOG){1'b0}}, s1_lz_q};
        cap_w = exp_w - W'(1);
        shift = s1_lz_q;
        if (exp_w[W-1] || (exp_w == '0)) begin
            shift = '0;
        end else if (cap_w < lz_w) begin
            shift = cap_w[XLOG-1:0];
        end
    end
`else
    always_comb begin
        shift = s1_lz_q;
    end
`endif

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mant_d   = s1_mant_q;
        s1_exp_d    = s1_exp_q;
        s1_lz_d     = s1_lz_q;
        s1_zero_d   = s1_zero_q;
        out_valid_d = out_valid_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_shift_d = out_shift_q;
        out_zero_d  = out_zero_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            s1_mant_d  = in_mant;
            s1_exp_d   = in_exp;
            s1_lz_d    = lz;
            s1_zero_d  = mant_zero;
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_zero_q) begin
                out_mant_d  = '0;
                out_exp_d   = '0;
                out_shift_d = '0;
                out_zero_d  = 1'b1;
            end else begin
                out_mant_d  = s1_mant_q << shift;
                out_exp_d   = s1_exp_q - ELEN'(shift);
                out_shift_d = shift;
                out_zero_d  = 1'b0;
            end
        end
    end

    // Stage-1 data needs no reset: it is qualified by s1_valid_q.
    always_ff @(posedge clock) begin
        s1_mant_q <= s1_mant_d;
        s1_exp_q  <= s1_exp_d;
        s1_lz_q   <= s1_lz_d;
        s1_zero_q <= s1_zero_d;
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_shift_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_shift_q <= out_shift_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_shift = out_shift_q;
    assign out_zero  = out_zero_q;

endmodule

// File: doc/fp_norm_pipe.md
FP_NORM_PIPE -- requirements
Module: fp_norm_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the mantissa width in bits (legal values 4, 8, 16, 32, 64, 128, 256).
REQ-002 The block SHALL have parameter XLOG, default 6, equal to log2(XLEN), giving the shift-count width.
REQ-003 The block SHALL have parameter ELEN, default 13, giving the signed two's-complement exponent width.
REQ-004 The block SHALL have port clock, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input operand valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts the operand this cycle.
REQ-008 The block SHALL have port in_mant, input, XLEN bits: unnormalized mantissa.
REQ-009 The block SHALL have port in_exp, input, ELEN bits: signed exponent.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-012 The block SHALL have port out_mant, output, XLEN bits: normalized mantissa.
REQ-013 The block SHALL have port out_exp, output, ELEN bits: adjusted signed exponent.
REQ-014 The block SHALL have port out_shift, output, XLOG bits: applied left-shift amount.
REQ-015 The block SHALL have port out_zero, output, 1 bit: in_mant was all zeros.

Function
REQ-016 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1, or where out_valid and out_ready are both 1.
REQ-017 The pipeline SHALL be two stages. Stage 1 registers the operand, its leading-zero count lz (number of zeros above the most significant 1) and a zero flag. Stage 2 registers the shifted mantissa, the exponent and the flags.
REQ-018 Latency from input transfer to out_valid SHALL be exactly 2 cycles when out_ready is held at 1.
REQ-019 Each stage SHALL advance when it is empty or when its downstream stage advances in the same cycle. in_ready SHALL equal (not s1_valid) or stage-1-advance. Combinational paths SHALL run only from ready to ready, never from valid to ready.
REQ-020 With out_ready held at 1, throughput SHALL be one operand per cycle with no bubbles.
REQ-021 While out_valid=1 and out_ready=0, out_mant, out_exp, out_shift and out_zero SHALL hold stable. Back-pressure SHALL stall stage 1 once stage 2 is full, and in_ready SHALL then fall to 0.
REQ-022 For a non-zero mantissa, the block SHALL produce:
- shift s per REQ-025/026
- out_mant = in_mant << s, with zero fill
- out_exp = in_exp - s, in ELEN-bit wrap-around arithmetic
- out_shift = s
- out_zero = 0
REQ-023 For in_mant = 0, the block SHALL produce out_zero=1, out_mant=0, out_exp=0 and out_shift=0.
REQ-024 If in_mant[XLEN-1]=1, then s=0 and out_exp=in_exp.

Configuration
REQ-025 With macro FP_NORM_DENORM_EN defined, s SHALL equal min(lz, in_exp-1) when in_exp >= 1, and s SHALL be 0 when in_exp <= 0, so that out_exp never falls below 1 because of the shift.
REQ-026 With FP_NORM_DENORM_EN undefined, s SHALL equal lz unconditionally, and out_exp may become zero or negative.

Reset
REQ-027 While reset=0 at a rising edge, both stage valid bits SHALL clear.
REQ-028 During reset, out_valid SHALL be 0, and out_mant, out_exp, out_shift and out_zero SHALL be 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operands. No result for them SHALL appear after reset is released.
REQ-031 Datapath registers other than the outputs SHALL need no reset value.

Verification
REQ-032 The bench SHALL cover, with XLEN=64, ELEN=13 and the macro undefined: in_mant=0x1, in_exp=100 -> out_mant=0x8000_0000_0000_0000, out_exp=37, out_shift=63, out_zero=0, two cycles after acceptance.
REQ-033 The bench SHALL cover: walking single 1 from bit 0 to bit 63 on consecutive cycles with out_ready=1 -> 64 results in order, with out_shift = 63 down to 0, no gaps, and the mantissa MSB set in every result.
REQ-034 The bench SHALL cover: in_mant=0, in_exp=-5 -> out_zero=1, out_mant=0, out_exp=0, out_shift=0.
REQ-035 The bench SHALL cover, with FP_NORM_DENORM_EN defined: in_mant=0x1, in_exp=10 -> out_shift=9, out_exp=1, out_mant=0x200; and in_exp=-3 -> out_shift=0, out_mant=0x1.
REQ-036 The bench SHALL cover: three operands sent with out_ready=0 -> in_ready=0 after two are accepted and outputs stable. Then out_ready=1 -> all three results delivered in order.
REQ-037 The bench SHALL cover: reset pulsed low for 1 cycle with two operands in flight -> out_valid=0 for the next 2 cycles and no stale result emitted.
